// File: rtl/serial_subtractor_if.sv
// Bus between a controller and the bit-serial subtractor: start/operands in,
// busy/done/result out. The signed-overflow flag exists only when
// SERIAL_SUB_OVF_EN is defined. state_dbg mirrors the FSM state for observation.
//
// Handshake: start is sampled only when busy=0 and done=0 (IDLE); the edge that
// samples start=1 also captures ip1/ip2. done is a one-cycle pulse, and
// difference/borrow (and ovf) are valid from that pulse until the next done.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] ip1;
  logic [WIDTH-1:0] ip2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow;
  logic [1:0]       state_dbg;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, ip1, ip2,
    input  busy, done, difference, borrow, state_dbg
`ifdef SERIAL_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, ip1, ip2,
    output busy, done, difference, borrow, state_dbg
`ifdef SERIAL_SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: difference = ip1 - ip2 mod 2^WIDTH.
// One full-subtractor cell is evaluated per clock and a borrow flip-flop chains
// the bits. Optional signed-overflow output is enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  // Holds the WIDTH-1 low result bits already produced; the final bit joins
  // them directly when the result is published.
  logic [WIDTH-2:0]   res_q, res_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               brw_q, brw_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs.
  logic bit_a, bit_b, bit_d, bit_bout;

  // Next-state, datapath and FSM transitions.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    brw_d    = brw_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif

    bit_a    = a_q[0];
    bit_b    = b_q[0];
    bit_d    = bit_a ^ bit_b ^ brw_q;
    bit_bout = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & brw_q);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.ip1;
          b_d     = bus.ip2;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = (WIDTH-1)'({bit_d, res_q} >> 1);
        brw_d = bit_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          diff_d   = {bit_d, res_q};
          borrow_d = bit_bout;
`ifdef SERIAL_SUB_OVF_EN
          // On the last bit a/b are the original operand MSBs.
          ovf_d    = (bit_a != bit_b) && (bit_d != bit_a);
`endif
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; asynchronous reset discards any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      brw_q    <= brw_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = (state_q == DONE);
  assign bus.difference = diff_q;
  assign bus.borrow     = borrow_q;
  assign bus.state_dbg  = state_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf        = ovf_q;
`endif

endmodule
